// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv
//
// ALU control for the RV32 datapath, with an optional iterative RV32M
// multiply/divide engine that sits in EX beside the ALU.
//
// Build option: define ALU_MULDIV_EN to include the multiply/divide engine.
// Without it, no engine registers exist. is_muldiv, in_ready, out_valid,
// md_busy and md_result are tied to 0, and funct7=0000001 R-format
// instructions decode as ordinary R-format by funct3.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   ALUOp          op class from main control
//   inst           current EX instruction
//   rs1_val        operand A (dividend / multiplier)
//   rs2_val        operand B (divisor / multiplicand)
//   ALU_selection  combinational ALU_* operation code
//   is_muldiv      combinational, current instruction is an M op
//   in_valid       EX holds a valid instruction
//   in_ready       engine idle, can accept
//   md_result      registered M-op result
//   out_valid      md_result valid
//   out_ready      consumer takes the result
//   md_busy        engine not idle (stall request to the hazard unit)
module alu_ctrl_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      ALUOp,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic [3:0]      ALU_selection,
   output logic            is_muldiv,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [XLEN-1:0] md_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            md_busy
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_PASS = 4'd10;

   logic [2:0] funct3;
   logic       isOpImm;
   logic       unusedInstBits;

   assign funct3         = inst[14:12];
   assign isOpImm        = (inst[6:2] == 5'b00100);
   assign unusedInstBits = ^inst;

   // ALU operation decode. This path is purely combinational and does not
   // depend on the engine. For OP-IMM, inst[30] is only meaningful for the
   // right shifts. ADDI must ignore it, because for ADDI that bit is part of
   // the immediate. For R-format, inst[30] also selects SUB over ADD.
   always_comb begin
      ALU_selection = ALU_ADD;
      case (ALUOp)
         2'b00: begin
            if (isOpImm) begin
               case (funct3)
                  3'b000:  ALU_selection = ALU_ADD;
                  3'b001:  ALU_selection = ALU_SLL;
                  3'b010:  ALU_selection = ALU_SLT;
                  3'b011:  ALU_selection = ALU_SLTU;
                  3'b100:  ALU_selection = ALU_XOR;
                  3'b101:  ALU_selection = inst[30] ? ALU_SRA : ALU_SRL;
                  3'b110:  ALU_selection = ALU_OR;
                  default: ALU_selection = ALU_AND;
               endcase
            end
         end
         2'b01:   ALU_selection = ALU_SUB;
         2'b11:   ALU_selection = ALU_PASS;
         default: begin
            case (funct3)
               3'b000:  ALU_selection = inst[30] ? ALU_SUB : ALU_ADD;
               3'b001:  ALU_selection = ALU_SLL;
               3'b010:  ALU_selection = ALU_SLT;
               3'b011:  ALU_selection = ALU_SLTU;
               3'b100:  ALU_selection = ALU_XOR;
               3'b101:  ALU_selection = inst[30] ? ALU_SRA : ALU_SRL;
               3'b110:  ALU_selection = ALU_OR;
               default: ALU_selection = ALU_AND;
            endcase
         end
      endcase
   end

`ifdef ALU_MULDIV_EN

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_VAL   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

   stateT             state, stateNext;
   logic [CW-1:0]     cnt;
   logic [2:0]        f3Reg;
   logic [XLEN-1:0]   opB;
   logic [2*XLEN-1:0] acc;
   logic              negRes;
   logic              negRem;
   logic [XLEN-1:0]   result;

   logic              accept;
   logic              aSigned, bSigned, aNeg, bNeg;
   logic [XLEN-1:0]   magA, magB;
   logic              divByZero, divOverflow, special;
   logic [XLEN-1:0]   specialResult;
   logic [XLEN:0]     mulSum;
   logic [2*XLEN-1:0] mulNext, mulFull;
   logic [XLEN:0]     divTrial;
   logic [2*XLEN-1:0] divNext;
   logic [XLEN-1:0]   mulResult, divResult, quo, rem;

   assign is_muldiv = (ALUOp == 2'b10) && (inst[31:25] == 7'b0000001);
   assign accept    = in_valid && in_ready && is_muldiv;
   assign in_ready  = (state == IDLE);
   assign md_busy   = (state != IDLE);
   assign out_valid = (state == DONE);
   assign md_result = result;

   // Decode at acceptance. This block works out which operands are signed,
   // takes their magnitudes, and spots the cases that skip iteration. MUL
   // (low half) is the same for any signedness, so it treats both operands
   // as unsigned. The magnitude of the most negative value still fits as
   // an unsigned XLEN-bit number.
   always_comb begin
      aSigned       = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
      bSigned       = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
      aNeg          = aSigned && rs1_val[XLEN-1];
      bNeg          = bSigned && rs2_val[XLEN-1];
      magA          = aNeg ? -rs1_val : rs1_val;
      magB          = bNeg ? -rs2_val : rs2_val;
      divByZero     = funct3[2] && (rs2_val == '0);
      divOverflow   = funct3[2] && !funct3[0] &&
                      (rs1_val == MIN_VAL) && (rs2_val == '1);
      special       = divByZero || divOverflow;
      specialResult = '0;
      if (divByZero) begin
         specialResult = funct3[1] ? rs1_val : '1;
      end else if (divOverflow) begin
         specialResult = funct3[1] ? '0 : rs1_val;
      end
   end

   // One iteration step for each algorithm, plus the final sign fix-up.
   // The multiplier works right-to-left. The low half of acc holds the
   // multiplier bits still to be used, and the high half collects partial
   // sums. The divider keeps the remainder in the high half and shifts the
   // dividend out of the low half while the quotient bits shift in. On the
   // last iteration the result is formed from these next values, so it
   // appears together with DONE.
   always_comb begin
      mulSum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opB} : '0);
      mulNext   = {mulSum, acc[XLEN-1:1]};
      mulFull   = negRes ? -mulNext : mulNext;
      mulResult = (f3Reg == 3'b000) ? mulFull[XLEN-1:0] : mulFull[2*XLEN-1:XLEN];

      divTrial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opB};
      if (!divTrial[XLEN]) begin
         divNext = {divTrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
         divNext = {acc[2*XLEN-2:0], 1'b0};
      end
      quo       = divNext[XLEN-1:0];
      rem       = divNext[2*XLEN-1:XLEN];
      divResult = f3Reg[1] ? (negRem ? -rem : rem) : (negRes ? -quo : quo);
   end

   // Engine state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state logic. Divide-by-zero and signed overflow go straight to
   // DONE. Everything else iterates XLEN times. DONE waits for the
   // consumer to take the result.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (special) begin
                  stateNext = DONE;
               end else if (funct3[2]) begin
                  stateNext = DIV;
               end else begin
                  stateNext = MUL;
               end
            end
         end
         MUL, DIV: begin
            if (cnt == LAST_ITER) begin
               stateNext = DONE;
            end
         end
         default: begin
            if (out_ready) begin
               stateNext = IDLE;
            end
         end
      endcase
   end

   // Datapath registers. Operands are latched only on acceptance, so later
   // changes on rs1_val/rs2_val have no effect on an operation in flight.
   // The result register holds its value through DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         f3Reg  <= '0;
         opB    <= '0;
         acc    <= '0;
         negRes <= 1'b0;
         negRem <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  f3Reg  <= funct3;
                  opB    <= magB;
                  acc    <= {{XLEN{1'b0}}, magA};
                  negRes <= aNeg ^ bNeg;
                  negRem <= aNeg;
                  if (special) begin
                     result <= specialResult;
                  end
               end
            end
            MUL: begin
               acc <= mulNext;
               cnt <= cnt + CW'(1);
               if (cnt == LAST_ITER) begin
                  result <= mulResult;
               end
            end
            DIV: begin
               acc <= divNext;
               cnt <= cnt + CW'(1);
               if (cnt == LAST_ITER) begin
                  result <= divResult;
               end
            end
            default: ;
         endcase
      end
   end

`else

   logic unusedEngineInputs;

   assign is_muldiv          = 1'b0;
   assign in_ready           = 1'b0;
   assign out_valid          = 1'b0;
   assign md_busy            = 1'b0;
   assign md_result          = '0;
   assign unusedEngineInputs = ^{clk, rst, in_valid, out_ready, rs1_val, rs2_val};

`endif

endmodule

// File: doc/alu_ctrl_muldiv.md
# alu_ctrl_muldiv

Next-generation ALU control for the RV32 datapath. It keeps combinational `ALU_*` selection decode for single-cycle ops and fixes OP-IMM shift decode. It adds an XLEN-parametrised, iterative multiply/divide engine for RV32M R-format instructions with a valid/ready handshake on both sides. It sits in EX beside the ALU; the hazard unit stalls the pipeline while the engine is busy.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; must be a power of two, ≥8.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `ALUOp`  in  2  op class from main control
- `inst`  in  32  current EX instruction
- `rs1_val`  in  XLEN  operand A
- `rs2_val`  in  XLEN  operand B
- `ALU_selection`  out  4  `ALU_*` code from defines.v, combinational
- `is_muldiv`  out  1  combinational: current inst is an M op
- `in_valid`  in  1  EX holds a valid instruction
- `in_ready`  out  1  engine idle, can accept
- `md_result`  out  XLEN  M-op result, registered
- `out_valid`  out  1  `md_result` valid
- `out_ready`  in  1  consumer takes result
- `md_busy`  out  1  engine state ≠ IDLE

## Operation
Decode (combinational, always active):
- `ALUOp`=00, `inst[6:2]`=00100 (OP-IMM), by funct3 `inst[14:12]`:
  - 000 → ADD
  - 001 → SLL
  - 010 → SLT
  - 011 → SLTU
  - 100 → XOR
  - 101 → SRA if `inst[30]`, else SRL
  - 110 → OR
  - 111 → AND
- `ALUOp`=00, other opcodes (load, store, JALR) → ADD.
- `ALUOp`=01 → SUB.
- `ALUOp`=11 → PASS.
- `ALUOp`=10, `inst[31:25]`≠0000001: R-format decode by funct3; 000 → SUB if `inst[30]`, else ADD; 101 → SRA if `inst[30]`, else SRL.
- `is_muldiv` = (`ALUOp`=10) & (`inst[31:25]`=0000001).

Engine (states IDLE, MUL, DIV, DONE):
- Accept when `in_valid & in_ready & is_muldiv`. Latch funct3, `rs1_val`, `rs2_val`; later input changes are ignored. Non-M instructions are never accepted.
- funct3:
  - 000 MUL (low XLEN)
  - 001 MULH (s×s high)
  - 010 MULHSU (s×u high)
  - 011 MULHU (u×u high)
  - 100 DIV
  - 101 DIVU
  - 110 REM
  - 111 REMU
- MUL state: shift-add on operand magnitudes, one bit per cycle, 2·XLEN-bit product. Negate at the end if the signed operand signs differ.
- DIV state: restoring division on magnitudes, one bit per cycle.
  - Quotient is negative if the signed operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, IDLE → DONE directly with no iteration:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (dividend = −2^(XLEN−1), divisor = −1): DIV → dividend; REM → 0.
- A counter of log2(XLEN)+1 bits counts iterations. After the XLEN-th iteration the state goes to DONE.
- DONE: `out_valid`=1 and `md_result` stable. The state moves to IDLE on the edge where `out_ready`=1.
- `in_ready` = (state = IDLE). `md_busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, `out_valid` 0, `md_result` 0, counter 0, `in_ready` 1, `md_busy` 0.
- Latency:
  - Call the accepting edge E0.
  - Iterating op: `out_valid` is high in the cycle after edge E_XLEN.
  - Special case: `out_valid` is high in the cycle after E0.
- DONE holds indefinitely while `out_ready`=0.
- New acceptance is possible in the cycle after DONE exits. Back-to-back issue costs one IDLE cycle.
- `rst` mid-operation aborts the operation. The next cycle is IDLE with `out_valid` 0 and the result discarded.
- `ALU_selection` has zero latency and is independent of engine state.

## Configuration
- `ALU_MULDIV_EN` defined: the engine and `is_muldiv` behave as described.
- `ALU_MULDIV_EN` undefined:
  - No engine registers are instantiated.
  - `is_muldiv`, `in_ready`, `out_valid` and `md_busy` are tied to 0; `md_result` is tied to 0.
  - funct7=0000001 R-format decodes as base R-format by funct3.

## Test plan
- Reset: `rst`=1 for 2 cycles → `in_ready`=1, `out_valid`=0, `md_result`=0, `md_busy`=0.
- MUL 7 × 0xFFFFFFFD → `out_valid` in the cycle after E32, `md_result`=0xFFFFFFEB. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 with 1-cycle latency. DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid` and `md_result` hold, `in_ready`=0. Then `out_ready`=1 → IDLE next cycle.
- Assert `rst` at iteration 10 of a MUL → IDLE next cycle, no `out_valid` pulse. A fresh MULHSU 0xFFFFFFFF × 2 then → 0xFFFFFFFF.
- Decode checks:
  - `ALUOp`=00, opcode 0010011, funct3 101, `inst[30]`=1 → ALU_SRA.
  - Build without `ALU_MULDIV_EN`: funct7=0000001, funct3 100 → ALU_XOR, `in_ready`=0.
